// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle.
// master: pipeline side (drives stage status, receives control).
// slave:  controller side.
// Optional PERF_CNT_EN adds the performance counter outputs.
interface pipe_hazard_ctrl_if
`ifdef PERF_CNT_EN
    #(parameter int unsigned CNT_W = 32)
`endif
    ;
    // Stage status
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_use_rs1;
    logic       id_use_rs2;
    logic       valid_id;
    logic       halt_id;
    logic [4:0] ex_rd;
    logic [4:0] mem_rd;
    logic [4:0] wb_rd;
    logic       ex_rwren;
    logic       mem_rwren;
    logic       wb_rwren;
    logic       valid_ex;
    logic       valid_mem;
    logic       valid_wb;
    logic       ex_pcsel;
    logic       halt_wb;
    logic       mem_wait;

    // Control
    logic       pc_wen;
    logic       if_id_wen;
    logic       id_ex_wen;
    logic       ex_mem_wen;
    logic       mem_wb_wen;
    logic       if_id_flush;
    logic       id_ex_flush;
    logic       fetch_halt;
    logic       halt;
    logic       timeout;

`ifdef PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic [CNT_W-1:0] wait_cnt;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, valid_id, halt_id,
               ex_rd, mem_rd, wb_rd, ex_rwren, mem_rwren, wb_rwren,
               valid_ex, valid_mem, valid_wb, ex_pcsel, halt_wb, mem_wait,
        input  pc_wen, if_id_wen, id_ex_wen, ex_mem_wen, mem_wb_wen,
               if_id_flush, id_ex_flush, fetch_halt, halt, timeout,
               stall_cnt, flush_cnt, wait_cnt
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, valid_id, halt_id,
               ex_rd, mem_rd, wb_rd, ex_rwren, mem_rwren, wb_rwren,
               valid_ex, valid_mem, valid_wb, ex_pcsel, halt_wb, mem_wait,
        output pc_wen, if_id_wen, id_ex_wen, ex_mem_wen, mem_wb_wen,
               if_id_flush, id_ex_flush, fetch_halt, halt, timeout,
               stall_cnt, flush_cnt, wait_cnt
    );
`else
    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, valid_id, halt_id,
               ex_rd, mem_rd, wb_rd, ex_rwren, mem_rwren, wb_rwren,
               valid_ex, valid_mem, valid_wb, ex_pcsel, halt_wb, mem_wait,
        input  pc_wen, if_id_wen, id_ex_wen, ex_mem_wen, mem_wb_wen,
               if_id_flush, id_ex_flush, fetch_halt, halt, timeout
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, valid_id, halt_id,
               ex_rd, mem_rd, wb_rd, ex_rwren, mem_rwren, wb_rwren,
               valid_ex, valid_mem, valid_wb, ex_pcsel, halt_wb, mem_wait,
        output pc_wen, if_id_wen, id_ex_wen, ex_mem_wen, mem_wb_wen,
               if_id_flush, id_ex_flush, fetch_halt, halt, timeout
    );
`endif
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Central sequencing controller for the 5-stage pipeline.
// Resolves RAW stalls (no forwarding), EX redirects, data-memory waits with a
// watchdog, and the halt drain. All *_wen outputs are active-low.
// Optional feature macro: PERF_CNT_EN (stall/flush/wait performance counters).
module pipe_hazard_ctrl #(
    parameter int unsigned WAIT_TIMEOUT = 255,
    parameter int unsigned CNT_W        = 32
) (
    input logic               clk,
    input logic               rst,
    pipe_hazard_ctrl_if.slave bus
);

    // Elaboration-time parameter sanity check
    if (WAIT_TIMEOUT < 1 || WAIT_TIMEOUT > 65535 || CNT_W < 1) begin : g_param_check
        $error("pipe_hazard_ctrl: WAIT_TIMEOUT must be 1..65535 and CNT_W >= 1");
    end

    typedef enum logic [1:0] {
        StRun    = 2'd0,
        StDrain  = 2'd1,
        StHalted = 2'd2
    } state_e;

    localparam logic [15:0] WaitMax = 16'(WAIT_TIMEOUT);

    state_e      state_q, state_d;
    logic [15:0] wait_q, wait_d;
    logic        timeout_q, timeout_d;

    logic haz, redir;
    logic rs1_hit, rs2_hit;

    logic pc_wen, if_id_wen, id_ex_wen, ex_mem_wen, mem_wb_wen;
    logic if_id_flush, id_ex_flush, fetch_halt;

    // True when a valid, register-writing stage targets register r.
    function automatic logic writes_reg(input logic       vld,
                                        input logic       rwren,
                                        input logic [4:0] rd,
                                        input logic [4:0] r);
        return vld & ~rwren & (rd == r);
    endfunction

    assign rs1_hit = writes_reg(bus.valid_ex,  bus.ex_rwren,  bus.ex_rd,  bus.id_rs1) |
                     writes_reg(bus.valid_mem, bus.mem_rwren, bus.mem_rd, bus.id_rs1) |
                     writes_reg(bus.valid_wb,  bus.wb_rwren,  bus.wb_rd,  bus.id_rs1);
    assign rs2_hit = writes_reg(bus.valid_ex,  bus.ex_rwren,  bus.ex_rd,  bus.id_rs2) |
                     writes_reg(bus.valid_mem, bus.mem_rwren, bus.mem_rd, bus.id_rs2) |
                     writes_reg(bus.valid_wb,  bus.wb_rwren,  bus.wb_rd,  bus.id_rs2);

    // x0 is hardwired, so it never creates a dependency.
    assign haz = bus.valid_id &
                 ((bus.id_use_rs1 & (bus.id_rs1 != 5'd0) & rs1_hit) |
                  (bus.id_use_rs2 & (bus.id_rs2 != 5'd0) & rs2_hit));
    assign redir = bus.valid_ex & bus.ex_pcsel;

    // Next-state and control outputs: per-cycle priority, then state overlay
    always_comb begin
        state_d     = state_q;
        pc_wen      = 1'b0;
        if_id_wen   = 1'b0;
        id_ex_wen   = 1'b0;
        ex_mem_wen  = 1'b0;
        mem_wb_wen  = 1'b0;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        fetch_halt  = 1'b0;

        if (bus.mem_wait) begin
            pc_wen     = 1'b1;
            if_id_wen  = 1'b1;
            id_ex_wen  = 1'b1;
            ex_mem_wen = 1'b1;
            mem_wb_wen = 1'b1;
        end else if (redir) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (haz) begin
            pc_wen      = 1'b1;
            if_id_wen   = 1'b1;
            id_ex_flush = 1'b1;
        end

        unique case (state_q)
            StRun: begin
                // A halt held back by a hazard simply waits in ID.
                if (bus.valid_id & bus.halt_id & ~haz & ~redir & ~bus.mem_wait) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                fetch_halt = 1'b1;
                // A live redirect still loads its target so the correct path resumes.
                if (bus.mem_wait || !redir) begin
                    pc_wen = 1'b1;
                end
                if (!bus.mem_wait) begin
                    if_id_flush = 1'b1;
                end
                if (!bus.mem_wait && redir) begin
                    state_d = StRun;
                end else if (!bus.mem_wait && bus.valid_wb && bus.halt_wb) begin
                    state_d = StHalted;
                end
            end
            StHalted: begin
                pc_wen      = 1'b1;
                if_id_wen   = 1'b1;
                id_ex_wen   = 1'b1;
                ex_mem_wen  = 1'b1;
                mem_wb_wen  = 1'b1;
                if_id_flush = 1'b0;
                id_ex_flush = 1'b0;
                fetch_halt  = 1'b1;
            end
            default: begin
                state_d = StRun;
            end
        endcase

        // Reset holds every register without waiting for a clock edge.
        if (!rst) begin
            pc_wen      = 1'b1;
            if_id_wen   = 1'b1;
            id_ex_wen   = 1'b1;
            ex_mem_wen  = 1'b1;
            mem_wb_wen  = 1'b1;
            if_id_flush = 1'b0;
            id_ex_flush = 1'b0;
            fetch_halt  = 1'b0;
        end
    end

    // Wait watchdog: saturating count of consecutive mem_wait cycles
    always_comb begin
        wait_d = 16'd0;
        if (bus.mem_wait) begin
            wait_d = (wait_q == WaitMax) ? wait_q : wait_q + 16'd1;
        end
        timeout_d = timeout_q | (bus.mem_wait & (wait_d == WaitMax));
    end

    // State, watchdog counter and sticky timeout registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StRun;
            wait_q    <= 16'd0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.pc_wen      = pc_wen;
    assign bus.if_id_wen   = if_id_wen;
    assign bus.id_ex_wen   = id_ex_wen;
    assign bus.ex_mem_wen  = ex_mem_wen;
    assign bus.mem_wb_wen  = mem_wb_wen;
    assign bus.if_id_flush = if_id_flush;
    assign bus.id_ex_flush = id_ex_flush;
    assign bus.fetch_halt  = fetch_halt;
    assign bus.halt        = (state_q == StHalted);
    assign bus.timeout     = timeout_q;

`ifdef PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q, wait_cnt_q;
    logic             cnt_run;

    assign cnt_run = (state_q != StHalted);

    // Saturating performance counters, frozen once halted
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            wait_cnt_q  <= '0;
        end else if (cnt_run) begin
            if (haz && !bus.mem_wait && stall_cnt_q != '1) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
            if (redir && flush_cnt_q != '1) begin
                flush_cnt_q <= flush_cnt_q + 1'b1;
            end
            if (bus.mem_wait && wait_cnt_q != '1) begin
                wait_cnt_q <= wait_cnt_q + 1'b1;
            end
        end
    end

    assign bus.stall_cnt = stall_cnt_q;
    assign bus.flush_cnt = flush_cnt_q;
    assign bus.wait_cnt  = wait_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: stimulus pushes expected control
// vectors, a monitor pops and compares them on each falling edge.
module tb_pipe_hazard_ctrl;

    // {pc, if_id, id_ex, ex_mem, mem_wb wen, if_id_flush, id_ex_flush, fetch_halt, halt, timeout}
    localparam logic [9:0] VHold   = 10'b11111_00000;
    localparam logic [9:0] VRun    = 10'b00000_00000;
    localparam logic [9:0] VStall  = 10'b11000_01000;
    localparam logic [9:0] VRedir  = 10'b00000_11000;
    localparam logic [9:0] VDrain  = 10'b10000_10100;
    localparam logic [9:0] VDrRed  = 10'b00000_11100;
    localparam logic [9:0] VHalted = 10'b11111_00110;
    localparam logic [9:0] VTo     = 10'b00000_00001;

    typedef struct {
        string      name;
        logic [9:0] exp;
    } exp_t;

    logic clk;
    logic rst;
    exp_t sb_q[$];
    int   n_checks;
    int   n_pass;
    int   n_err;

    pipe_hazard_ctrl_if bus ();

    pipe_hazard_ctrl #(
        .WAIT_TIMEOUT(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic idle();
        bus.id_rs1     = 5'd0;
        bus.id_rs2     = 5'd0;
        bus.id_use_rs1 = 1'b0;
        bus.id_use_rs2 = 1'b0;
        bus.valid_id   = 1'b0;
        bus.halt_id    = 1'b0;
        bus.ex_rd      = 5'd0;
        bus.mem_rd     = 5'd0;
        bus.wb_rd      = 5'd0;
        bus.ex_rwren   = 1'b1;
        bus.mem_rwren  = 1'b1;
        bus.wb_rwren   = 1'b1;
        bus.valid_ex   = 1'b0;
        bus.valid_mem  = 1'b0;
        bus.valid_wb   = 1'b0;
        bus.ex_pcsel   = 1'b0;
        bus.halt_wb    = 1'b0;
        bus.mem_wait   = 1'b0;
    endtask

    task automatic expect_out(input string name, input logic [9:0] exp);
        exp_t e;
        e.name = name;
        e.exp  = exp;
        sb_q.push_back(e);
    endtask

    // Lets the monitor sample this cycle, then moves to just after the next rising edge.
    task automatic step();
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic raw_ex(input logic [4:0] rs1);
        idle();
        bus.valid_id   = 1'b1;
        bus.id_use_rs1 = 1'b1;
        bus.id_rs1     = rs1;
        bus.valid_ex   = 1'b1;
        bus.ex_rwren   = 1'b0;
        bus.ex_rd      = 5'd5;
    endtask

    // Monitor
    initial begin
        exp_t       e;
        logic [9:0] act;
        n_checks = 0;
        n_pass   = 0;
        forever begin
            @(negedge clk);
            while (sb_q.size() > 0) begin
                e   = sb_q.pop_front();
                act = {bus.pc_wen, bus.if_id_wen, bus.id_ex_wen, bus.ex_mem_wen,
                       bus.mem_wb_wen, bus.if_id_flush, bus.id_ex_flush,
                       bus.fetch_halt, bus.halt, bus.timeout};
                n_checks++;
                if (act !== e.exp) begin
                    $display("FAIL %s: got %b expected %b", e.name, act, e.exp);
                end else begin
                    n_pass++;
                end
            end
        end
    end

    // Stimulus
    initial begin
        n_err = 0;
        rst = 1'b0;
        idle();
        #1;
        if (bus.halt !== 1'b0 || bus.timeout !== 1'b0 || bus.pc_wen !== 1'b1 ||
            bus.if_id_wen !== 1'b1 || bus.id_ex_wen !== 1'b1 || bus.ex_mem_wen !== 1'b1 ||
            bus.mem_wb_wen !== 1'b1 || bus.if_id_flush !== 1'b0 ||
            bus.id_ex_flush !== 1'b0 || bus.fetch_halt !== 1'b0) begin
            $display("FAIL reset_state_direct: halt=%b timeout=%b pc_wen=%b",
                     bus.halt, bus.timeout, bus.pc_wen);
            n_err++;
        end
        expect_out("reset", VHold);
        step();
        rst = 1'b1;
        expect_out("idle_run", VRun);
        step();

        // RAW hazards
        raw_ex(5'd5);
        expect_out("raw_ex", VStall);
        step();
        raw_ex(5'd0);
        expect_out("raw_r0", VRun);
        step();
        idle();
        bus.valid_id = 1'b1; bus.id_use_rs2 = 1'b1; bus.id_rs2 = 5'd7;
        bus.valid_mem = 1'b1; bus.mem_rwren = 1'b0; bus.mem_rd = 5'd7;
        expect_out("raw_mem_rs2", VStall);
        step();
        idle();
        bus.valid_id = 1'b1; bus.id_use_rs2 = 1'b1; bus.id_rs2 = 5'd9;
        bus.valid_wb = 1'b1; bus.wb_rwren = 1'b1; bus.wb_rd = 5'd9;
        expect_out("raw_wb_nowrite", VRun);
        step();
        raw_ex(5'd5);
        bus.valid_id = 1'b0;
        expect_out("haz_invalid_id", VRun);
        step();

        // Redirects
        idle();
        bus.valid_ex = 1'b1; bus.ex_pcsel = 1'b1;
        expect_out("redir", VRedir);
        step();
        bus.valid_ex = 1'b0;
        expect_out("redir_invalid", VRun);
        step();
        raw_ex(5'd5);
        bus.ex_pcsel = 1'b1;
        expect_out("redir_over_haz", VRedir);
        step();

        // Short memory wait: freeze, no timeout
        for (int k = 0; k < 3; k++) begin
            idle();
            if (k == 0) begin
                bus.valid_ex = 1'b1; bus.ex_pcsel = 1'b1;
            end
            bus.mem_wait = 1'b1;
            expect_out($sformatf("wait3_c%0d", k), VHold);
            step();
        end
        idle();
        expect_out("wait3_after", VRun);
        step();

        // Long memory wait: timeout from the 4th wait edge, sticky
        for (int k = 1; k <= 6; k++) begin
            idle();
            bus.mem_wait = 1'b1;
            expect_out($sformatf("wait6_c%0d", k), (k > 4) ? (VHold | VTo) : VHold);
            step();
        end
        idle();
        #1;
        if (bus.timeout !== 1'b1) begin
            $display("FAIL expired_wait_direct: timeout=%b expected 1", bus.timeout);
            n_err++;
        end
        expect_out("timeout_sticky", VRun | VTo);
        step();
        rst = 1'b0;
        expect_out("reset_clears_timeout", VHold);
        step();
        rst = 1'b1;

        // Halt drain
        idle();
        bus.valid_id = 1'b1; bus.halt_id = 1'b1;
        expect_out("halt_in_id", VRun);
        step();
        idle();
        bus.valid_ex = 1'b1;
        expect_out("drain_ex", VDrain);
        step();
        idle();
        bus.valid_mem = 1'b1;
        expect_out("drain_mem", VDrain);
        step();
        idle();
        bus.valid_wb = 1'b1; bus.halt_wb = 1'b1;
        expect_out("drain_wb", VDrain);
        step();
        idle();
        expect_out("halted", VHalted);
        step();
        idle();
        bus.valid_id = 1'b1; bus.halt_id = 1'b1;
        bus.valid_ex = 1'b1; bus.ex_pcsel = 1'b1; bus.mem_wait = 1'b1;
        expect_out("halted_absorb", VHalted);
        step();

        // Asynchronous reset while halted, between clock edges
        idle();
        #1;
        rst = 1'b0;
        expect_out("async_rst_halted", VHold);
        step();
        rst = 1'b1;

        // Halt blocked by a hazard stays in RUN
        idle();
        bus.valid_id = 1'b1; bus.halt_id = 1'b1; bus.id_use_rs1 = 1'b1; bus.id_rs1 = 5'd3;
        bus.valid_wb = 1'b1; bus.wb_rwren = 1'b0; bus.wb_rd = 5'd3;
        expect_out("halt_haz_stall", VStall);
        step();
        idle();
        expect_out("halt_haz_stays_run", VRun);
        step();

        // Wrong-path halt cancelled by a redirect during DRAIN
        idle();
        bus.valid_id = 1'b1; bus.halt_id = 1'b1;
        expect_out("wp_halt_id", VRun);
        step();
        idle();
        bus.valid_ex = 1'b1; bus.ex_pcsel = 1'b1;
        expect_out("wp_redir_in_drain", VDrRed);
        step();
        idle();
        bus.valid_wb = 1'b1; bus.halt_wb = 1'b1;
        expect_out("wp_back_run", VRun);
        step();
        idle();
        expect_out("wp_no_halt", VRun);
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        if (n_pass != n_checks || n_err != 0) begin
            $display("FAIL summary: %0d scoreboard mismatches, %0d direct failures",
                     n_checks - n_pass, n_err);
        end else begin
            $display("PASS");
        end
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central sequencing controller for the 5-stage pipeline (IF, ID, EX, MEM, WB).
- Drives the active-low WEN hold inputs and the bubble/flush inputs of the four pipeline registers, plus the PC write enable and fetch halt.
- Resolves RAW stalls (there is no forwarding), EX-stage branch/jump redirects and multi-cycle data-memory waits.
- Sequences the halt drain so the top-level `halt` asserts only once a valid halt instruction has retired.

Parameters:
- WAIT_TIMEOUT, 255, max consecutive mem_wait cycles before `timeout` sets (1..65535).
- CNT_W, 32, width of the performance counters (used only with PERF_CNT_EN).

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  asynchronous, active-low reset.
- id_rs1, id_rs2  in  5 each  source registers of the instruction in ID.
- id_use_rs1, id_use_rs2  in  1 each  instruction in ID reads rs1/rs2.
- valid_id  in  1  ID stage holds a real instruction.
- halt_id  in  1  instruction in ID decodes as halt.
- ex_rd, mem_rd, wb_rd  in  5 each  destination registers in EX/MEM/WB.
- ex_rwren, mem_rwren, wb_rwren  in  1 each  register write enable, active-low (0 = writes).
- valid_ex, valid_mem, valid_wb  in  1 each  stage-valid bits.
- ex_pcsel  in  1  EX resolved a taken branch or jump (redirect).
- halt_wb  in  1  instruction in WB is halt.
- mem_wait  in  1  data memory not ready; freeze the whole pipeline.
- pc_wen, if_id_wen, id_ex_wen, ex_mem_wen, mem_wb_wen  out  1 each  active-low load (0 = load, 1 = hold).
- if_id_flush, id_ex_flush  out  1 each  load valid=0 into that register on the next edge.
- fetch_halt  out  1  IF stops fetching and emits valid=0.
- halt  out  1  CPU halted (sticky).
- timeout  out  1  mem_wait watchdog tripped (sticky).

Behaviour:
- Reset (rst=0, async):
  - state=RUN; halt=0; timeout=0; wait counter=0; perf counters=0.
  - All wen outputs=1 (hold); flushes=0; fetch_halt=0.
- Hazard (combinational):
  - haz = valid_id & ((id_use_rs1 & id_rs1!=0 & match(id_rs1)) | (id_use_rs2 & id_rs2!=0 & match(id_rs2))).
  - match(r) = (valid_ex & ~ex_rwren & ex_rd==r) | same for MEM | same for WB.
  - Register 0 never causes a hazard.
- Redirect: redir = valid_ex & ex_pcsel.
- Per-cycle priority, highest first:
  1. mem_wait=1:
     - all wen=1, no flushes.
     - Wait counter increments, saturating at WAIT_TIMEOUT.
     - Counter reaching WAIT_TIMEOUT sets timeout; the pipeline stays frozen.
  2. redir:
     - all wen=0.
     - if_id_flush=1, id_ex_flush=1 (two-instruction penalty).
     - A pending DRAIN returns to RUN, since the halt in ID was wrong-path.
  3. haz:
     - pc_wen=1, if_id_wen=1 (hold).
     - id_ex_wen=0 with id_ex_flush=1 (bubble).
     - ex_mem_wen=0, mem_wb_wen=0.
  4. Otherwise: all wen=0, no flushes.
- Wait counter clears on any cycle with mem_wait=0.
- FSM states:
  - RUN:
    - valid_id & halt_id & ~haz & ~redir & ~mem_wait → DRAIN.
    - A halt stalled by haz waits in ID.
  - DRAIN:
    - fetch_halt=1; pc_wen=1.
    - if_id_flush=1 except when mem_wait=1.
    - valid_wb & halt_wb & ~mem_wait → HALTED.
  - HALTED:
    - halt=1; all wen=1; fetch_halt=1.
    - Absorbing until reset.
- Latency: halt rises on the edge after the cycle in which the valid halt sits in WB.
- Reset mid-operation: immediate return to reset values regardless of state.

Optional Feature:
- Macro: PERF_CNT_EN.
- When defined, adds three outputs, each CNT_W wide, cleared on reset and saturating at all-ones:
  - stall_cnt: cycles with haz and no mem_wait.
  - flush_cnt: redir cycles.
  - wait_cnt: mem_wait cycles.
- Counters freeze in HALTED.
- When undefined, these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- RAW on EX: valid_ex=1, ex_rwren=0, ex_rd=5; ID uses rs1=5 → pc_wen=1, if_id_wen=1, id_ex_flush=1. The same stimulus with id_rs1=0 → no stall.
- Branch redirect: ex_pcsel=1, valid_ex=1 → if_id_flush=1, id_ex_flush=1, all wen=0. The same stimulus with valid_ex=0 → ignored.
- Mem wait with WAIT_TIMEOUT=4: mem_wait high for 3 cycles → all wen=1, timeout=0. Mem_wait high for 6 cycles → timeout=1 from the 4th wait-cycle edge and stays set after mem_wait drops.
- Halt drain: halt in ID → fetch_halt=1 next cycle. Halt reaches WB three edges later → halt=1 one edge after that and stays 1.
- Wrong-path halt: halt enters DRAIN, then redir asserts the same cycle → state returns to RUN, fetch_halt=0, halt never asserts.
- Async reset in HALTED: rst=0 mid-cycle → halt=0 and all wen=1 immediately, without waiting for a clock edge.
